fpdiv_seq: RTL
==============

Name: fpdiv_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point divider. It is the sequential successor to the combinational fpdiv. Width is configurable through EXP_W and MAN_W. Operands and results move over valid/ready handshakes, and IEEE exception flags are reported with each result. The mantissa quotient is computed by a radix-2 restoring divider, one quotient bit per cycle, so one divider serves the datapath at low area.

Parameters:
EXP_W, 8, exponent field width (8 = single, 5 = half)
MAN_W, 23, stored fraction width (23 = single, 10 = half)
W, EXP_W+MAN_W+1, total operand width (derived, not overridable)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  divider can accept operands
a  in  W  dividend, {sign, exp, frac}
b  in  W  divisor, same format
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W  quotient a/b
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset: in_ready=0 during the reset cycle, then 1. out_valid=0, result=0, flags=0, state=IDLE.
- If rst is asserted mid-operation, the operation is abandoned. No result is produced and the next state is IDLE.
- Handshake rules:
  - Operands are accepted on a clock edge where in_valid&&in_ready. in_ready=1 only in IDLE.
  - Result is transferred on out_valid&&out_ready. out_valid, result and flags hold stable until that transfer.
  - After the transfer, the next state is IDLE. There is no back-to-back accept in the same cycle.
- States:
  - IDLE -> UNPACK on accept.
  - UNPACK -> DONE for special cases; otherwise UNPACK -> DIV.
  - DIV runs MAN_W+3 cycles, counted by a counter, then -> ROUND.
  - ROUND -> DONE.
  - DONE -> IDLE on out_ready.
- Latency, counted from the accept edge k:
  - Normal operands: out_valid rises at edge k+MAN_W+6 (29 cycles for the defaults).
  - Special cases: out_valid rises at edge k+2.
  - Latency does not depend on the data.
- Denormal inputs are treated as signed zero (DAZ). Results are never denormal (FTZ).
- Result sign is sa^sb in all cases, including zero and inf. The exception is NaN, which is always the canonical form.
- Canonical qNaN = {0, all-ones exp, 1, zeros}, e.g. 0x7FC00000 for single.
- Special cases, evaluated in UNPACK in this priority order:
  1. Either operand NaN -> qNaN, invalid=1.
  2. 0/0 or inf/inf -> qNaN, invalid=1.
  3. inf/x -> signed inf, no flags.
  4. x/0 (x finite, nonzero) -> signed inf, div_by_zero=1.
  5. 0/x or x/inf -> signed zero, no flags.
- Normal path:
  - Mantissas are ma={1,fa} and mb={1,fb}, each MAN_W+1 bits.
  - The divider produces MAN_W+3 quotient bits of ma/mb, in [0.5,2).
  - Sticky = (remainder != 0).
  - If the quotient MSB is 0, shift left by 1 and decrement the exponent.
  - Biased exponent = ea - eb + bias, with bias = 2^(EXP_W-1)-1. It is computed in EXP_W+2 signed bits.
  - Rounding is round-to-nearest-even using the guard bit, the round bit and sticky. inexact = guard|round|sticky.
  - A mantissa carry-out from rounding increments the exponent.
- Range limits:
  - Exponent >= 2^EXP_W-1 after rounding -> signed inf, overflow=1, inexact=1.
  - Exponent <= 0 -> signed zero, underflow=1, inexact=1.

Test Plan:
- Defaults, a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result 0x40400000, flags 0, out_valid exactly 29 cycles after accept.
- a=0x3F800000, b=0x00000000 -> 0x7F800000, div_by_zero=1, out_valid 2 cycles after accept. Then a=b=0 -> 0x7FC00000, invalid=1. Then a=0xBF800000, b=0x7F800000 -> 0x80000000, flags 0.
- a=0x3F800000, b=0x40400000 (1/3) -> 0x3EAAAAAB, inexact=1. Instance with EXP_W=5, MAN_W=10: a=0x3C00, b=0x4200 -> 0x3555, inexact=1, latency 16.
- Overflow and underflow:
  - a=0x7F000000, b=0x3E800000 -> 0x7F800000, overflow=1, inexact=1.
  - a=0x00800000, b=0x7F000000 -> 0x00000000, underflow=1, inexact=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and flags stable, in_ready=0. Raise out_ready -> transfer occurs, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst 5 cycles into DIV -> out_valid=0 and in_ready=1 the cycle after reset is released. The next op, 6.0/2.0, yields the correct 0x40400000.

Source files
------------

// File: rtl/fpdiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpdiv_seq_if
//  Description : Operand/result handshake bundle for the sequential
//                floating-point divider. The master drives operands and
//                accepts results; the slave is the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpdiv_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fpdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpdiv_seq
//  Description : Multi-cycle IEEE-754-style divider. Radix-2 restoring
//                mantissa division (one quotient bit per cycle), RNE
//                rounding, DAZ inputs / FTZ outputs, exception flags
//                {invalid, div_by_zero, overflow, underflow, inexact}.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpdiv_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic       clk,
    input  logic       rst,
    fpdiv_seq_if.slave bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int QW = MAN_W + 3;          // quotient bits produced
    localparam int RW = MAN_W + 2;          // partial remainder width
    localparam int XW = EXP_W + 2;          // signed working exponent width
    localparam int CW = $clog2(QW + 1);

    localparam logic [CW-1:0]        LAST_STEP = CW'(QW - 1);
    localparam logic signed [XW-1:0] BIAS      = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_NONE  = '0;
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]     EXP_ZERO  = '0;
    localparam logic [MAN_W-1:0]     MAN_ZERO  = '0;
    localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [4:0] F_INVALID = 5'b10000;
    localparam logic [4:0] F_DBZ     = 5'b01000;
    localparam logic [4:0] F_OVF     = 5'b00100;
    localparam logic [4:0] F_UNF     = 5'b00010;
    localparam logic [4:0] F_INX     = 5'b00001;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              in_ready_q, out_valid_q;
    logic [W-1:0]      result_q;
    logic [4:0]        flags_q;
    logic [W-1:0]      a_q, b_q;
    logic [RW-1:0]     rem_q;
    logic [MAN_W:0]    div_q;
    logic [QW-1:0]     quo_q;
    logic [CW-1:0]     cnt_q;
    logic signed [XW-1:0] exp_q;
    logic              sign_q;

    // FSM strobes
    logic accept, do_unpack, do_step, do_round, set_valid, xfer;

    // Operand fields of the captured pair
    logic              sa, sb, sq;
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  fa, fb;
    logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic signed [XW-1:0] unp_exp;

    assign sa = a_q[W-1];
    assign sb = b_q[W-1];
    assign sq = sa ^ sb;
    assign ea = a_q[W-2:MAN_W];
    assign eb = b_q[W-2:MAN_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    // Denormals collapse to zero, so a zero exponent alone means zero
    assign zero_a = (ea == EXP_ZERO);
    assign zero_b = (eb == EXP_ZERO);
    assign inf_a  = (ea == EXP_ONES) && (fa == MAN_ZERO);
    assign inf_b  = (eb == EXP_ONES) && (fb == MAN_ZERO);
    assign nan_a  = (ea == EXP_ONES) && (fa != MAN_ZERO);
    assign nan_b  = (eb == EXP_ONES) && (fb != MAN_ZERO);

    assign unp_exp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // Special-case classification, highest priority first
    logic         is_special;
    logic [W-1:0] spec_res;
    logic [4:0]   spec_flags;

    always_comb begin
        is_special = 1'b1;
        spec_res   = QNAN;
        spec_flags = F_INVALID;
        if (nan_a || nan_b) begin
            spec_res   = QNAN;
            spec_flags = F_INVALID;
        end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_res   = QNAN;
            spec_flags = F_INVALID;
        end else if (inf_a) begin
            spec_res   = {sq, EXP_ONES, MAN_ZERO};
            spec_flags = 5'b00000;
        end else if (zero_b) begin
            spec_res   = {sq, EXP_ONES, MAN_ZERO};
            spec_flags = F_DBZ;
        end else if (zero_a || inf_b) begin
            spec_res   = {sq, EXP_ZERO, MAN_ZERO};
            spec_flags = 5'b00000;
        end else begin
            is_special = 1'b0;
            spec_res   = '0;
            spec_flags = 5'b00000;
        end
    end

    // One restoring-division step: subtract divisor when it fits, then shift
    logic          step_ge;
    logic [RW-1:0] rem_next;

    always_comb begin
        step_ge  = (rem_q >= {1'b0, div_q});
        rem_next = (step_ge ? (rem_q - {1'b0, div_q}) : rem_q) << 1;
    end

    // Normalise, round to nearest even and apply the range limits
    logic                 q_msb, guard_b, round_b, sticky_b, round_up, rnd_carry;
    logic [MAN_W-1:0]     frac_pre, frac_rnd;
    logic signed [XW-1:0] rnd_exp;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flags;

    always_comb begin
        q_msb    = quo_q[QW-1];
        sticky_b = (rem_q != '0);
        if (q_msb) begin
            frac_pre = quo_q[QW-2:2];
            guard_b  = quo_q[1];
            round_b  = quo_q[0];
        end else begin
            // Quotient below 1.0: one extra quotient bit becomes the LSB
            frac_pre = quo_q[QW-3:1];
            guard_b  = quo_q[0];
            round_b  = 1'b0;
        end
        round_up = guard_b & (round_b | sticky_b | frac_pre[0]);
        {rnd_carry, frac_rnd} = {1'b0, frac_pre} + {{MAN_W{1'b0}}, round_up};
        rnd_exp = $signed(exp_q - {{(XW-1){1'b0}}, ~q_msb} + {{(XW-1){1'b0}}, rnd_carry});
        if (rnd_exp >= EXP_MAX) begin
            rnd_res   = {sign_q, EXP_ONES, MAN_ZERO};
            rnd_flags = F_OVF | F_INX;
        end else if (rnd_exp <= EXP_NONE) begin
            rnd_res   = {sign_q, EXP_ZERO, MAN_ZERO};
            rnd_flags = F_UNF | F_INX;
        end else begin
            rnd_res   = {sign_q, rnd_exp[EXP_W-1:0], frac_rnd};
            rnd_flags = (guard_b | round_b | sticky_b) ? F_INX : 5'b00000;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_UNPACK;
            S_UNPACK: state_d = is_special ? S_DONE : S_DIV;
            S_DIV:    if (cnt_q == LAST_STEP) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (xfer) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        accept    = 1'b0;
        do_unpack = 1'b0;
        do_step   = 1'b0;
        do_round  = 1'b0;
        set_valid = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            S_IDLE:   accept    = bus.in_valid && in_ready_q;
            S_UNPACK: do_unpack = 1'b1;
            S_DIV:    do_step   = 1'b1;
            S_ROUND:  do_round  = 1'b1;
            S_DONE: begin
                set_valid = !out_valid_q;
                xfer      = out_valid_q && bus.out_ready;
            end
            default: ;
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
        end else begin
            in_ready_q <= (state_d == S_IDLE);
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (do_unpack) begin
                sign_q <= sq;
                rem_q  <= {1'b0, 1'b1, fa};
                div_q  <= {1'b1, fb};
                quo_q  <= '0;
                cnt_q  <= '0;
                exp_q  <= unp_exp;
                if (is_special) begin
                    result_q <= spec_res;
                    flags_q  <= spec_flags;
                end
            end
            if (do_step) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[QW-2:0], step_ge};
                cnt_q <= cnt_q + CW'(1);
            end
            if (do_round) begin
                result_q <= rnd_res;
                flags_q  <= rnd_flags;
            end
            if (set_valid)  out_valid_q <= 1'b1;
            else if (xfer)  out_valid_q <= 1'b0;
        end
    end
endmodule
`default_nettype wire
